// File: rtl/spi_rom_arbiter.sv
// Two-port read arbiter and SPI READ (0x03) sequencer for an M95xxx serial EEPROM.
// Define SPI_ROM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

module spi_rom_arbiter #(
  parameter int SCK_HALF   = 4,
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [ADDR_BITS-1:0]    addr0,
  input  logic [ADDR_BITS-1:0]    addr1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [8*DATA_BYTES-1:0] rdata0,
  output logic [8*DATA_BYTES-1:0] rdata1,
  output logic                    busy,
  output logic                    spi_clk_out,
  output logic                    mosi_out,
  output logic                    spi_en_out,
  input  logic                    miso
);

  localparam int TOTAL = 8 + ADDR_BITS + 8*DATA_BYTES;
  localparam int DW    = 8*DATA_BYTES;
  localparam int CNT_W = $clog2(2*SCK_HALF);
  localparam int BIT_W = $clog2(TOTAL);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(SCK_HALF - 1);
  localparam logic [CNT_W-1:0] DESEL_M1 = CNT_W'(2*SCK_HALF - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD, CS_HIGH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [TOTAL-1:0]  tx_q, tx_d;
  logic [DW-1:0]     rx_q, rx_d;
  logic              winner_q, winner_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DW-1:0]     rdata0_q, rdata0_d;
  logic [DW-1:0]     rdata1_q, rdata1_d;

  logic              any_req;
  logic              pick1;
  logic [TOTAL-1:0]  load_tx;

  assign any_req = req0 | req1;

`ifdef SPI_ROM_ARB_RR_EN
  // Pointer 0 favours port 0 on a tie; it flips on every grant.
  logic ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         ptr_q <= 1'b0;
    else if (state_q == IDLE && any_req) ptr_q <= ~ptr_q;
  end

  assign pick1 = req1 && (!req0 || ptr_q);
`else
  assign pick1 = req1 && !req0;
`endif

  assign load_tx = {8'h03, (pick1 ? addr1 : addr0), {DW{1'b0}}};

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    winner_d = winner_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          winner_d = pick1;
          tx_d     = load_tx;
          mosi_d   = load_tx[TOTAL-1];
          bit_d    = LAST_BIT;
          cnt_d    = HALF_M1;
          sck_d    = 1'b0;
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = HALF_M1;
          if (!sck_q) begin
            // Rising SCK edge: the EEPROM's bit has been stable for the whole low phase.
            sck_d = 1'b1;
            rx_d  = {rx_q[DW-2:0], miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q == '0) begin
              state_d = CS_HOLD;
            end else begin
              bit_d  = bit_q - BIT_W'(1);
              tx_d   = {tx_q[TOTAL-2:0], 1'b0};
              mosi_d = tx_q[TOTAL-2];
            end
          end
        end
      end

      CS_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cs_n_d  = 1'b1;
          cnt_d   = DESEL_M1;
          state_d = CS_HIGH;
          if (winner_q) begin
            ack1_d   = 1'b1;
            rdata1_d = rx_q;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = rx_q;
          end
        end
      end

      CS_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      winner_q <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      winner_q <= winner_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = busy_q;
  assign spi_clk_out = sck_q;
  assign mosi_out    = mosi_q;
  assign spi_en_out  = cs_n_q;

endmodule
